pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline stage register; successor to the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM).

---
 rtl/pipe_pkg.sv | 56 +++++
 rtl/pipe_skid_buf.sv | 39 +++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and control-word field offsets
package pipe_pkg;

    // ID/EX slot: A 8 + B 8 + instruction 19
    localparam int ID_EX_DATA_W = 35;
    localparam int ID_EX_CTRL_W = 13;

    // EX/MEM slot: ALU result 8 + store data 8 + destination register 3
    localparam int EX_MEM_DATA_W = 19;
    localparam int EX_MEM_CTRL_W = 4;

    // ID/EX control word bit offsets
    localparam int CTRL_WRITE_Z           = 0;
    localparam int CTRL_WRITE_C           = 1;
    localparam int CTRL_SELECT_Z          = 2;
    localparam int CTRL_SELECT_C          = 3;
    localparam int CTRL_ALU_IN_MUX        = 4;
    localparam int CTRL_ALU_USE_CARRY     = 5;
    localparam int CTRL_REG_WRITE         = 6;
    localparam int CTRL_MEM_WRITE         = 7;
    localparam int CTRL_ALU_OP_LSB        = 8;
    localparam int CTRL_ALU_OP_W          = 3;
    localparam int CTRL_REG_WRITE_MUX_LSB = 11;
    localparam int CTRL_REG_WRITE_MUX_W   = 2;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic       alu_use_carry;
        logic       alu_in_mux;
        logic       select_c;
        logic       select_z;
        logic       write_c;
        logic       write_z;
        logic [2:0] alu_op;
        logic [1:0] reg_write_mux;
    } id_ex_ctrl_t;

    // Builds the control vector field by field so the bit layout lives only here
    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t f);
        logic [ID_EX_CTRL_W-1:0] v;
        v = '0;
        v[CTRL_MEM_WRITE]     = f.mem_write;
        v[CTRL_REG_WRITE]     = f.reg_write;
        v[CTRL_ALU_USE_CARRY] = f.alu_use_carry;
        v[CTRL_ALU_IN_MUX]    = f.alu_in_mux;
        v[CTRL_SELECT_C]      = f.select_c;
        v[CTRL_SELECT_Z]      = f.select_z;
        v[CTRL_WRITE_C]       = f.write_c;
        v[CTRL_WRITE_Z]       = f.write_z;
        v[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W]               = f.alu_op;
        v[CTRL_REG_WRITE_MUX_LSB +: CTRL_REG_WRITE_MUX_W] = f.reg_write_mux;
        return v;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry skid holding valid, data and control
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              skid_valid,
    output logic [DATA_W-1:0] skid_data,
    output logic [CTRL_W-1:0] skid_ctrl
);

    // Park a word while the output is stalled; drain or squash clears the entry
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else begin
            if (flush || unload) begin
                skid_valid <= 1'b0;
            end else if (load) begin
                skid_valid <= 1'b1;
            end
            if (load && !flush) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register, optional skid via PIPE_STAGE_SKID_EN
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  stall_q;

    logic              out_free;
    logic              accept;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;

    logic              nxt_valid;
    logic [DATA_W-1:0] nxt_data;
    logic [CTRL_W-1:0] nxt_ctrl;

    assign out_free = !valid_q || out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Registered ready: no combinational path from out_ready to in_ready
    assign in_ready = flush || !skid_valid;
    assign accept   = in_valid && in_ready && !flush;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (accept && !out_free),
        .unload     (out_free && skid_valid),
        .flush      (flush),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .skid_valid (skid_valid),
        .skid_data  (skid_data),
        .skid_ctrl  (skid_ctrl)
    );

    // The parked word is older than anything arriving, so it feeds the output first
    assign src_valid = skid_valid || accept;
    assign src_data  = skid_valid ? skid_data : in_data;
    assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
`else
    assign in_ready  = flush || out_free;
    assign accept    = in_valid && in_ready && !flush;
    assign src_valid = accept;
    assign src_data  = in_data;
    assign src_ctrl  = in_ctrl;
`endif

    // Next output contents: flush bubbles, a free slot loads the oldest pending word
    always_comb begin
        nxt_valid = valid_q;
        nxt_data  = data_q;
        nxt_ctrl  = ctrl_q;
        if (flush) begin
            nxt_valid = 1'b0;
        end else if (out_free) begin
            nxt_valid = src_valid;
            if (src_valid) begin
                nxt_data = src_data;
                nxt_ctrl = src_ctrl;
            end
        end
    end

    // Output register and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= nxt_valid;
            data_q  <= nxt_data;
            ctrl_q  <= nxt_ctrl;
            if (valid_q && !out_ready && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_ONE;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = valid_q ? ctrl_q : '0;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW      = 35;
    localparam int CW      = 13;
    localparam int NW      = 4;
    localparam int CNT_TOP = 15;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    word_t q[$];
    int    m_cnt;
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ready, advance the word-queue model, check outputs
    task automatic step(input logic rst, input logic iv, input logic ordy, input logic fl,
                        input logic [DW-1:0] d, input logic [CW-1:0] c);
        logic  m_rdy;
        word_t w;
        reset = rst; in_valid = iv; out_ready = ordy; flush = fl; in_data = d; in_ctrl = c;
        @(negedge clk);
        m_rdy = fl || (SKID ? (q.size() < 2) : (q.size() == 0 || ordy));
        if (!rst) chk("in_ready", 64'(in_ready), 64'(m_rdy));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (q.size() > 0 && !ordy && m_cnt < CNT_TOP) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (iv && m_rdy) begin
                    w.d = d;
                    w.c = c;
                    q.push_back(w);
                end
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("out_ctrl", 64'(out_ctrl), (q.size() > 0) ? 64'(q[0].c) : 64'd0);
        if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [CW-1:0] rw_ctrl;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '0; in_ctrl = '0; m_cnt = 0;

        // 1: reset held two cycles while upstream offers a word
        step(1, 1, 0, 0, 35'h5, 13'h1FFF);
        step(1, 1, 0, 0, 35'h6, 13'h1FFF);
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);

        // 2: back-to-back streaming, one cycle latency, no gaps
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 1, 0, DW'(k), CW'(k + 16));
            chk("t2_out_valid", 64'(out_valid), 64'd1);
            chk("t2_out_data", 64'(out_data), 64'(k));
        end
        step(0, 0, 1, 0, '0, '0);
        chk("t2_drained", 64'(out_valid), 64'd0);

        // 3: stall five cycles on a full control word
        step(1, 0, 0, 0, '0, '0);
        step(0, 1, 1, 0, 35'h100, 13'h1FFF);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, rnd_data(), CW'($urandom()));
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("t3_out_data", 64'(out_data), 64'h100);
        chk("t3_out_ctrl", 64'(out_ctrl), 64'h1FFF);
        chk("t3_in_ready", 64'(in_ready), 64'd0);

        // 4: flush a live register-writing word while a new word is offered
        step(1, 0, 0, 0, '0, '0);
        rw_ctrl = '0;
        rw_ctrl[CTRL_REG_WRITE] = 1'b1;
        step(0, 1, 1, 0, 35'h77, rw_ctrl);
        step(0, 1, 0, 1, 35'h88, rw_ctrl);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_out_ctrl", 64'(out_ctrl), 64'd0);
        step(0, 0, 1, 0, '0, '0);
        chk("t4_dropped", 64'(out_valid), 64'd0);

        // 5: counter saturates at 15 over 20 stall cycles
        step(1, 0, 0, 0, '0, '0);
        step(0, 1, 1, 0, 35'h3C, 13'h3);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, '0, '0);
        chk("t5_stall_sat", 64'(stall_cnt), 64'd15);
        chk("t5_out_held", 64'(out_data), 64'h3C);

`ifdef PIPE_STAGE_SKID_EN
        // 6: two words held across a stall, released in order
        step(1, 0, 0, 0, '0, '0);
        step(0, 1, 0, 0, 35'hA, 13'h1);
        step(0, 1, 0, 0, 35'hB, 13'h2);
        step(0, 0, 0, 0, '0, '0);
        chk("t6_in_ready", 64'(in_ready), 64'd0);
        chk("t6_head", 64'(out_data), 64'hA);
        step(0, 0, 1, 0, '0, '0);
        chk("t6_second", 64'(out_data), 64'hB);
        chk("t6_second_valid", 64'(out_valid), 64'd1);
        step(0, 0, 1, 0, '0, '0);
        chk("t6_empty", 64'(out_valid), 64'd0);
`endif

        // Randomized traffic against the queue model
        step(1, 0, 0, 0, '0, '0);
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
                 rnd_data(), CW'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
